// File: rtl/ghash_pkg.sv
// rtl/ghash_pkg.sv - shared types and constants for the GHASH accumulator
package ghash_pkg;

    localparam int GF_W        = 128;
    localparam int C_G1_W_DFLT = 22;

    typedef logic [GF_W-1:0] gf128_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        MUL  = 2'd2,
        HOLD = 2'd3
    } ghash_st_e;

endpackage

// File: rtl/gf_mul_128_0.sv
// rtl/gf_mul_128_0.sv - combinational GF(2^128) multiply, reduced by x^128+x^7+x^2+x+1
module gf_mul_128_0
    import ghash_pkg::*;
#(
    parameter int C_G1_W = C_G1_W_DFLT
) (
    input  logic              rst_n,
    input  logic [C_G1_W-1:0] C_g1,
    input  gf128_t            a,
    input  gf128_t            b,
    output gf128_t            c
);

    // Full reduction polynomial aligned at bit 128; shifted down onto each overflow bit.
    localparam logic [2*GF_W-2:0] POLY = {126'b0, 1'b1, 120'b0, 8'h87};

    logic [2*GF_W-2:0] prod;
    logic              unused_cfg;

    always_comb begin
        prod = '0;
        for (int i = 0; i < GF_W; i++) begin
            if (b[i]) begin
                prod = prod ^ ({127'b0, a} << i);
            end
        end
        for (int i = 2*GF_W-2; i >= GF_W; i--) begin
            if (prod[i]) begin
                prod = prod ^ (POLY << (i - GF_W));
            end
        end
    end

    assign c          = rst_n ? prod[GF_W-1:0] : '0;
    assign unused_cfg = ^C_g1;

endmodule

// File: rtl/ghash_acc_128.sv
// rtl/ghash_acc_128.sv - block-serial GHASH accumulator in front of gf_mul_128_0
module ghash_acc_128
    import ghash_pkg::*;
#(
    parameter int C_G1_W = C_G1_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [C_G1_W-1:0] C_g1,
    input  logic              h_load,
    input  logic [127:0]      h_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_tag
);

    ghash_st_e state;
    ghash_st_e state_nxt;
    gf128_t    h_key;
    gf128_t    y_acc;
    gf128_t    x_op;
    gf128_t    product;
    logic      last_q;
    logic      ready_q;
    logic      accept;

    gf_mul_128_0 #(
        .C_G1_W (C_G1_W)
    ) u_mul (
        .rst_n (rst_n),
        .C_g1  (C_g1),
        .a     (x_op),
        .b     (h_key),
        .c     (product)
    );

    assign accept = in_valid & ready_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MUL;
            ACC:     if (accept) state_nxt = MUL;
            MUL:     state_nxt = last_q ? HOLD : ACC;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            h_key   <= '0;
            y_acc   <= '0;
            x_op    <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            // Registered copy of the next state's readiness keeps in_ready off every input path.
            ready_q <= (state_nxt == IDLE) || (state_nxt == ACC);
            case (state)
                IDLE: begin
                    if (h_load) begin
                        h_key <= h_in;
                    end
                    if (accept) begin
                        x_op   <= in_data;
                        last_q <= in_last;
                    end
                end
                ACC: begin
                    if (accept) begin
                        x_op   <= y_acc ^ in_data;
                        last_q <= in_last;
                    end
                end
                MUL: begin
                    y_acc <= product;
                end
                HOLD: begin
                    if (out_ready) begin
                        y_acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state == HOLD);
    assign out_tag   = (state == HOLD) ? y_acc : '0;

endmodule

// File: tb/tb_ghash_acc_128.sv
// tb/tb_ghash_acc_128.sv - self-checking bench for ghash_acc_128
module tb_ghash_acc_128;
    import ghash_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [21:0]   C_g1;
    logic          h_load;
    logic [127:0]  h_in;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_tag;

    always #5 clk = ~clk;

    ghash_acc_128 #(.C_G1_W(22)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .C_g1      (C_g1),
        .h_load    (h_load),
        .h_in      (h_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag)
    );

    typedef struct {
        string  name;
        gf128_t h;
        int     nblk;
        gf128_t blk [4];
        gf128_t exp;
    } vec_t;

    vec_t vecs [6];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Bit-serial Horner reference: z = z*x mod P, then add a when b's bit is set.
    function automatic gf128_t gf_ref(input gf128_t a, input gf128_t b);
        gf128_t z = '0;
        logic   carry;
        for (int i = 127; i >= 0; i--) begin
            carry = z[127];
            z     = z << 1;
            if (carry) z = z ^ 128'h87;
            if (b[i])  z = z ^ a;
        end
        return z;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out, got no handshake expected one", name);
    endtask

    // Returns at posedge+1 of the cycle after the accept (the MUL cycle).
    task automatic send_block(input gf128_t d, input logic last, input logic ld,
                              input gf128_t hv, input int gap);
        logic ok = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        h_load   = ld;
        h_in     = hv;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        h_load   = 1'b0;
        if (!ok) timeout("send_block");
        else     check("in_ready_in_mul", {127'b0, in_ready}, 128'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  {127'b0, in_ready},  128'h0);
        check("reset_out_valid", {127'b0, out_valid}, 128'h0);
        check("reset_out_tag",   out_tag,             128'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Table vectors: also checks the exact 2-cycle tag latency and the 1-cycle tag.
    task automatic run_vec(input vec_t v);
        for (int b = 0; b < v.nblk; b++) begin
            send_block(v.blk[b], b == v.nblk - 1, b == 0, v.h, 0);
        end
        check({v.name, "_valid_t1"}, {127'b0, out_valid}, 128'h0);
        @(posedge clk);
        #1;
        check({v.name, "_valid_t2"}, {127'b0, out_valid}, 128'h1);
        check({v.name, "_tag"},      out_tag,             v.exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({v.name, "_idle_valid"}, {127'b0, out_valid}, 128'h0);
        check({v.name, "_idle_ready"}, {127'b0, in_ready},  128'h1);
    endtask

    initial begin
        gf128_t h, d, y;
        int     nb;
        logic   ok;

        vecs[0].name = "ident1";  vecs[0].h = 128'h1; vecs[0].nblk = 1;
        vecs[0].blk[0] = 128'hDEADBEEF;
        vecs[0].exp = 128'hDEADBEEF;
        vecs[1].name = "ident2";  vecs[1].h = 128'h1; vecs[1].nblk = 2;
        vecs[1].blk[0] = 128'hF0F0; vecs[1].blk[1] = 128'h0FF0;
        vecs[1].exp = 128'hFF00;
        vecs[2].name = "shiftx";  vecs[2].h = 128'h2; vecs[2].nblk = 2;
        vecs[2].blk[0] = 128'h1; vecs[2].blk[1] = 128'h0;
        vecs[2].exp = 128'h4;
        vecs[3].name = "reduce1"; vecs[3].h = {1'b1, 127'b0}; vecs[3].nblk = 1;
        vecs[3].blk[0] = 128'h2;
        vecs[3].exp = 128'h87;
        vecs[4].name = "reduce2"; vecs[4].h = {1'b1, 127'b0}; vecs[4].nblk = 1;
        vecs[4].blk[0] = {1'b1, 127'b0};
        vecs[4].exp = 128'hC000_0000_0000_0000_0000_0000_0000_1067;
        vecs[5].name = "xplus1";  vecs[5].h = 128'h3; vecs[5].nblk = 2;
        vecs[5].blk[0] = 128'h5; vecs[5].blk[1] = 128'h0;
        vecs[5].exp = 128'h11;

        C_g1      = '0;
        h_load    = 1'b0;
        h_in      = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        do_reset();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Backpressure: tag held, input blocked, key pulses ignored.
        send_block(128'h1234_5678, 1'b1, 1'b1, 128'h1, 0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            h_load = 1'b1;
            h_in   = 128'h2;
            @(negedge clk);
            check("bp_valid", {127'b0, out_valid}, 128'h1);
            check("bp_tag",   out_tag,             128'h1234_5678);
            check("bp_ready", {127'b0, in_ready},  128'h0);
            @(posedge clk);
            #1;
        end
        h_load    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_ready", {127'b0, in_ready},  128'h1);
        check("bp_release_valid", {127'b0, out_valid}, 128'h0);
        check("bp_release_tag",   out_tag,             128'h0);
        run_vec('{name: "bp_fresh", h: 128'h1, nblk: 1,
                  blk: '{128'h55, 128'h0, 128'h0, 128'h0}, exp: 128'h55});

        // Reset while in MUL discards the message and clears the key.
        send_block(128'hABCD, 1'b0, 1'b1, 128'h7, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_mid_valid", {127'b0, out_valid}, 128'h0);
        check("rst_mid_tag",   out_tag,             128'h0);
        @(posedge clk);
        #1;
        send_block(128'h1234, 1'b1, 1'b0, 128'h0, 0);
        @(posedge clk);
        #1;
        check("rst_h_zero_valid", {127'b0, out_valid}, 128'h1);
        check("rst_h_zero_tag",   out_tag,             128'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Random messages against the software reference.
        for (int m = 0; m < 200; m++) begin
            h  = {$urandom, $urandom, $urandom, $urandom};
            nb = $urandom_range(1, 8);
            y  = '0;
            for (int b = 0; b < nb; b++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                y = gf_ref(y ^ d, h);
                send_block(d, b == nb - 1, b == 0, h, $urandom_range(0, 2));
            end
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (out_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                timeout("rand_tag_wait");
            end else begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                check("rand_tag", out_tag, y);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
